// File: rtl/instr_split_pkg.sv
// rtl/instr_split_pkg.sv - field positions, opcodes and format tags for the instruction splitter
package instr_split_pkg;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;
    localparam int SH_HI = 10;
    localparam int SH_LO = 6;
    localparam int FN_HI = 5;
    localparam int FN_LO = 0;
    localparam int IMM16_HI = 15;
    localparam int IMM26_HI = 25;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_J = 2'd2
    } fmt_e;

    // logical immediates are zero-extended, everything else sign-extends
    function automatic logic is_zext_op(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// rtl/instr_field_decode.sv - combinational split of a 32-bit MIPS word into its fields
module instr_field_decode
    import instr_split_pkg::*;
#(
    parameter int IMM_W = 32
) (
    input  logic [31:0]      instr,
    output logic [5:0]       op,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       func,
    output logic [15:0]      imm16,
    output logic [25:0]      imm26,
    output logic [IMM_W-1:0] imm_ext,
    output logic [1:0]       fmt
);

    assign op    = instr[OP_HI:OP_LO];
    assign rs    = instr[RS_HI:RS_LO];
    assign rt    = instr[RT_HI:RT_LO];
    assign rd    = instr[RD_HI:RD_LO];
    assign shamt = instr[SH_HI:SH_LO];
    assign func  = instr[FN_HI:FN_LO];
    assign imm16 = instr[IMM16_HI:0];
    assign imm26 = instr[IMM26_HI:0];

    // fill the upper immediate bits first so IMM_W==16 needs no special case
    always_comb begin
        imm_ext       = (is_zext_op(op) || !instr[IMM16_HI]) ? '0 : '1;
        imm_ext[15:0] = instr[IMM16_HI:0];
    end

    // classify the instruction format from the opcode alone
    always_comb begin
        fmt = FMT_I;
        if (op == OP_RTYPE) begin
            fmt = FMT_R;
        end else if ((op == OP_J) || (op == OP_JAL)) begin
            fmt = FMT_J;
        end
    end

endmodule

// File: rtl/instr_split_queue.sv
// rtl/instr_split_queue.sv - fetch-to-decode FIFO presenting the head instruction pre-split
module instr_split_queue
    import instr_split_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int DEPTH = 2,
    parameter int IMM_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [5:0]               op,
    output logic [4:0]               rs,
    output logic [4:0]               rt,
    output logic [4:0]               rd,
    output logic [4:0]               shamt,
    output logic [5:0]               func,
    output logic [15:0]              imm16,
    output logic [25:0]              imm26,
    output logic [IMM_W-1:0]         imm_ext,
    output logic [1:0]               fmt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [31:0]     instr_mem [DEPTH];
    logic [PC_W-1:0] pc_mem    [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level_q;
    logic            push;
    logic            pop;
    logic [31:0]     head_instr;

    // ready is a pure function of occupancy, so out_ready never reaches in_ready
    assign in_ready  = (level_q < DEPTH_L);
    assign out_valid = (level_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign level     = level_q;

    // pointers and occupancy; flush wins over any handshake in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    // storage is left unreset; occupancy alone decides what is meaningful
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    // an all-zero word decodes to all-zero fields, so gating the head word zeroes every output
    assign head_instr = out_valid ? instr_mem[rd_ptr] : 32'h0;
    assign out_pc     = out_valid ? pc_mem[rd_ptr] : '0;

    instr_field_decode #(
        .IMM_W(IMM_W)
    ) u_decode (
        .instr   (head_instr),
        .op      (op),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .func    (func),
        .imm16   (imm16),
        .imm26   (imm26),
        .imm_ext (imm_ext),
        .fmt     (fmt)
    );

endmodule

// File: tb/tb_instr_split_queue.sv
// tb/tb_instr_split_queue.sv - scoreboard bench for instr_split_queue
module tb_instr_split_queue;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] i16;
        logic [25:0] i26;
        logic [31:0] iext;
        logic [1:0]  fmt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [31:0] out_pc;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] imm_ext;
    logic [1:0]  fmt;
    logic [1:0]  level;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_pc;
    logic [5:0]  s_op, s_func;
    logic [4:0]  s_rs, s_rt, s_rd, s_shamt;
    logic [15:0] s_imm16;
    logic [25:0] s_imm26;
    logic [15:0] s_imm_ext;
    logic [1:0]  s_fmt;
    logic [1:0]  s_level;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    exp_t vec[8];

    always #5 clk = ~clk;

    instr_split_queue #(.PC_W(32), .DEPTH(2), .IMM_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
        .imm16(imm16), .imm26(imm26), .imm_ext(imm_ext), .fmt(fmt), .level(level)
    );

    instr_split_queue #(.PC_W(32), .DEPTH(2), .IMM_W(16)) dut16 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc),
        .op(s_op), .rs(s_rs), .rt(s_rt), .rd(s_rd), .shamt(s_shamt), .func(s_func),
        .imm16(s_imm16), .imm26(s_imm26), .imm_ext(s_imm_ext), .fmt(s_fmt), .level(s_level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                                input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                                input logic [15:0] i16, input logic [25:0] i26,
                                input logic [31:0] iext, input logic [1:0] f);
        exp_t e;
        e.instr = instr; e.pc = pc; e.op = o; e.rs = s; e.rt = t; e.rd = d; e.sh = sh;
        e.fn = fn; e.i16 = i16; e.i26 = i26; e.iext = iext; e.fmt = f;
        return e;
    endfunction

    // offer one word; record the expectation on the accepting edge
    task automatic push(input exp_t e);
        int n;
        logic rdy;
        n = 0;
        rdy = 1'b0;
        in_valid = 1'b1;
        in_instr = e.instr;
        in_pc = e.pc;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 100);
        if (rdy) sb.push_back(e);
        else chk("push_timeout", 32'd0, 32'd1);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    // monitor: every accepted head is compared against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && !flush && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pop", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("op", 32'(op), 32'(e.op));
                    chk("rs", 32'(rs), 32'(e.rs));
                    chk("rt", 32'(rt), 32'(e.rt));
                    chk("rd", 32'(rd), 32'(e.rd));
                    chk("shamt", 32'(shamt), 32'(e.sh));
                    chk("func", 32'(func), 32'(e.fn));
                    chk("imm16", 32'(imm16), 32'(e.i16));
                    chk("imm26", 32'(imm26), 32'(e.i26));
                    chk("imm_ext", imm_ext, e.iext);
                    chk("fmt", 32'(fmt), 32'(e.fmt));
                    chk("imm_ext_w16", 32'(s_imm_ext), 32'(e.i16));
                end
            end
        end
    end

    initial begin
        vec[0] = mk(32'h012A4020, 32'h3000, 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h4020, 26'h12A4020, 32'h00004020, 2'd0);
        vec[1] = mk(32'h2108FFFF, 32'h3004, 6'h08, 5'd8, 5'd8, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h108FFFF, 32'hFFFFFFFF, 2'd1);
        vec[2] = mk(32'h3508FFFF, 32'h3008, 6'h0D, 5'd8, 5'd8, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h108FFFF, 32'h0000FFFF, 2'd1);
        vec[3] = mk(32'h08100004, 32'h300C, 6'h02, 5'd0, 5'd16, 5'd0, 5'd0, 6'h04, 16'h0004, 26'h0100004, 32'h00000004, 2'd2);
        vec[4] = mk(32'h0C000010, 32'h3010, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h10, 16'h0010, 26'h0000010, 32'h00000010, 2'd2);
        vec[5] = mk(32'h30008000, 32'h3014, 6'h0C, 5'd0, 5'd0, 5'd16, 5'd0, 6'h00, 16'h8000, 26'h0008000, 32'h00008000, 2'd1);
        vec[6] = mk(32'h38008001, 32'h3018, 6'h0E, 5'd0, 5'd0, 5'd16, 5'd0, 6'h01, 16'h8001, 26'h0008001, 32'h00008001, 2'd1);
        vec[7] = mk(32'h8C008000, 32'h301C, 6'h23, 5'd0, 5'd0, 5'd16, 5'd0, 6'h00, 16'h8000, 26'h0008000, 32'hFFFF8000, 2'd1);

        // reset state, before any clock edge
        #3;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_op", 32'(op), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_imm_ext", imm_ext, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // first word: no bypass, visible one cycle after the accepting edge
        out_ready = 1'b1;
        @(negedge clk);
        chk("empty_before_push", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        push(vec[0]);
        chk("valid_after_push", 32'(out_valid), 32'd1);
        wait_drain();

        // remaining decode patterns back to back
        for (int i = 1; i < 8; i++) push(vec[i]);
        wait_drain();

        // full queue holds a third word until the consumer pops
        out_ready = 1'b0;
        push(mk(32'h2108FFFF, 32'h5000, 6'h08, 5'd8, 5'd8, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h108FFFF, 32'hFFFFFFFF, 2'd1));
        push(mk(32'h3508FFFF, 32'h5004, 6'h0D, 5'd8, 5'd8, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h108FFFF, 32'h0000FFFF, 2'd1));
        fork
            push(mk(32'h08100004, 32'h5008, 6'h02, 5'd0, 5'd16, 5'd0, 5'd0, 6'h04, 16'h0004, 26'h0100004, 32'h00000004, 2'd2));
            begin
                repeat (3) @(negedge clk);
                chk("full_in_ready", 32'(in_ready), 32'd0);
                chk("full_level", 32'(level), 32'd2);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // pointer wrap: ten back-to-back words with occupancy sitting at one
        fork
            for (int i = 0; i < 10; i++)
                push(mk(32'h20000000 | 32'(i), 32'h4000 + 32'(4 * i), 6'h08, 5'd0, 5'd0, 5'd0, 5'd0,
                        6'(i), 16'(i), 26'(i), 32'(i), 2'd1));
            begin
                @(negedge clk);
                repeat (9) begin
                    @(negedge clk);
                    chk("wrap_level", 32'(level), 32'd1);
                end
            end
        join
        wait_drain();

        // flush with a full queue and a simultaneous offer
        out_ready = 1'b0;
        push(vec[1]);
        push(vec[2]);
        @(negedge clk);
        chk("pre_flush_level", 32'(level), 32'd2);
        @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid = 1'b1;
        in_instr = vec[3].instr;
        in_pc = 32'h9999;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_op", 32'(op), 32'd0);
        chk("flush_out_pc", out_pc, 32'd0);
        chk("flush_imm_ext", imm_ext, 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("flush_dropped", 32'(out_valid), 32'd0);

        // asynchronous reset mid-cycle with one entry queued
        @(posedge clk);
        #1;
        push(vec[0]);
        @(negedge clk);
        chk("pre_reset_level", 32'(level), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_level", 32'(level), 32'd0);
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_out_pc", out_pc, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // queue still works after reset
        out_ready = 1'b1;
        push(vec[7]);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
